controller_uart_rx_arbiter: RTL

Owns the read side of the UART1 receive FIFO and shares it between two consumers: the CPU, with a single-byte request/ack, and a streaming sink, with valid/ready. Tracks FIFO occupancy as a 10-bit level. That level drives the in_port of the uart1_rx_counter PIO, so software can poll it. Arbitration is round-robin, with one byte granted per arbitration.

---
 rtl/controller_uart_rx_pkg.sv | 22 ++
 rtl/controller_uart_rx_level.sv | 63 ++++++
 rtl/controller_uart_rx_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/controller_uart_rx_pkg.sv
// Shared types and defaults for the UART1 receive-FIFO read arbiter.
package controller_uart_rx_pkg;

   localparam int unsigned DATA_W_DEFAULT = 8;
   localparam int unsigned CNT_W_DEFAULT  = 10;
   localparam int unsigned DEPTH_DEFAULT  = 1023;

   typedef enum logic [1:0] {IDLE, READ, CAPTURE, DELIVER} state_t;

   typedef enum logic {GNT_CPU, GNT_STREAM} grant_t;

   // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
   function automatic grant_t pick_winner(input logic   cpu_req,
                                          input logic   st_en,
                                          input grant_t last_grant);
      if (cpu_req && st_en) begin
         return (last_grant == GNT_STREAM) ? GNT_CPU : GNT_STREAM;
      end
      return cpu_req ? GNT_CPU : GNT_STREAM;
   endfunction

endpackage

// File: rtl/controller_uart_rx_level.sv
// FIFO occupancy counter with a sticky overflow flag for pushes that arrive while full.
module controller_uart_rx_level
   import controller_uart_rx_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             overflow
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             inc_ok;

   assign full   = (count_q == CNT_W'(DEPTH));
   assign inc_ok = inc & ~full;

   always_comb begin
      count_d = count_q;
      if (inc_ok && !dec) begin
         count_d = count_q + CNT_W'(1);
      end else if (!inc_ok && dec && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // A full-push in the same cycle as a clear keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (inc && full) begin
         overflow_d = 1'b1;
      end else if (clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign count    = count_q;
   assign overflow = overflow_q;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!(dec && (count_q == '0)));
      end
   end

endmodule

// File: rtl/controller_uart_rx_arbiter.sv
// Shares the UART1 receive FIFO read port between a CPU request/ack consumer and a
// valid/ready stream sink, one byte per round-robin grant.
module controller_uart_rx_arbiter
   import controller_uart_rx_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned CNT_W  = CNT_W_DEFAULT,
   parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_push,
   output logic              fifo_rdreq,
   input  logic [DATA_W-1:0] fifo_q,
   output logic [CNT_W-1:0]  rx_count,
   output logic              overflow,
   input  logic              overflow_clr,
   input  logic              cpu_req,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_data,
   input  logic              st_en,
   output logic              st_valid,
   input  logic              st_ready,
   output logic [DATA_W-1:0] st_data
);

   state_t            state_q, state_d;
   grant_t            winner_q, winner_d;
   grant_t            last_grant_q, last_grant_d;
   logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
   logic [DATA_W-1:0] st_data_q, st_data_d;
   logic              level_full;

   controller_uart_rx_level #(
      .CNT_W (CNT_W),
      .DEPTH (DEPTH)
   ) u_level (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (rx_push),
      .dec      (fifo_rdreq),
      .clr      (overflow_clr),
      .count    (rx_count),
      .full     (level_full),
      .overflow (overflow)
   );

   always_comb begin
      state_d      = state_q;
      winner_d     = winner_q;
      last_grant_d = last_grant_q;
      cpu_data_d   = cpu_data_q;
      st_data_d    = st_data_q;
      fifo_rdreq   = 1'b0;
      cpu_ack      = 1'b0;
      st_valid     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ((rx_count != '0) && (cpu_req || st_en)) begin
               winner_d     = pick_winner(cpu_req, st_en, last_grant_q);
               last_grant_d = winner_d;
               state_d      = READ;
            end
         end
         READ: begin
            fifo_rdreq = 1'b1;
            state_d    = CAPTURE;
         end
         CAPTURE: begin
            if (winner_q == GNT_CPU) begin
               cpu_data_d = fifo_q;
            end else begin
               st_data_d = fifo_q;
            end
            state_d = DELIVER;
         end
         DELIVER: begin
            // The granted byte is delivered even if the requester has since dropped out.
            if (winner_q == GNT_CPU) begin
               cpu_ack = 1'b1;
               state_d = IDLE;
            end else begin
               st_valid = 1'b1;
               if (st_ready) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         winner_q     <= GNT_CPU;
         last_grant_q <= GNT_STREAM;
         cpu_data_q   <= '0;
         st_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         winner_q     <= winner_d;
         last_grant_q <= last_grant_d;
         cpu_data_q   <= cpu_data_d;
         st_data_q    <= st_data_d;
      end
   end

   assign cpu_data = cpu_data_q;
   assign st_data  = st_data_q;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (level_full || (rx_count < CNT_W'(DEPTH)));
      end
   end

endmodule
